// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: issues in-order PC requests to instruction memory and queues {PC, instruction} pairs for decode.
// Optional build macro FETCH_PERF_EN enables the fetch/drop performance counters.
module inst_fetch_unit #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_out_cnt, r_q_cnt, r_drop_cnt;
  logic [CNT_W-1:0]   w_out_nxt, w_drop_nxt, w_remain;
  logic [PTR_W-1:0]   r_pend_wr, r_pend_rd, r_q_wr, r_q_rd;
  logic [ADDR_W-1:0]  r_pend_pc [DEPTH];
  logic [ADDR_W-1:0]  r_q_pc    [DEPTH];
  logic [INST_W-1:0]  r_q_inst  [DEPTH];

  logic               w_space, w_accept, w_resp_ok, w_push, w_pop, w_clear;
  logic [CNT_W:0]     w_used;

  // Outstanding requests plus queued results may never exceed the queue depth.
  assign w_used    = {1'b0, r_out_cnt} + {1'b0, r_q_cnt};
  assign w_space   = w_used < (CNT_W+1)'(DEPTH);
  assign imem_req  = !reset && (r_state == ST_RUN) && pc_valid && w_space && !flush;
  assign imem_addr = pc_in;
  assign w_accept  = imem_req && imem_gnt;
  assign pc_ready  = w_accept;

  assign w_resp_ok = imem_rvalid && (r_out_cnt != '0);
  assign w_remain  = r_out_cnt - CNT_W'(w_resp_ok);

  assign inst_valid = (r_q_cnt != '0);
  assign w_pop      = inst_valid && inst_ready;
  assign inst_out   = inst_valid ? r_q_inst[r_q_rd] : '0;
  assign inst_pc    = inst_valid ? r_q_pc[r_q_rd]   : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out_cnt;
    w_drop_nxt  = r_drop_cnt;
    w_push      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (flush) begin
          // Requests still in flight after this edge must be swallowed in DRAIN.
          w_clear   = 1'b1;
          w_out_nxt = '0;
          if (w_remain != '0) begin
            w_state_nxt = ST_DRAIN;
            w_drop_nxt  = w_remain;
          end
        end else begin
          w_push    = w_resp_ok;
          w_out_nxt = r_out_cnt + CNT_W'(w_accept) - CNT_W'(w_resp_ok);
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid && (r_drop_cnt != '0)) begin
          w_drop_nxt = r_drop_cnt - CNT_W'(1);
          if (r_drop_cnt == CNT_W'(1)) w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_q_cnt    <= '0;
      r_pend_wr  <= '0;
      r_pend_rd  <= '0;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_out_cnt  <= w_out_nxt;
      r_drop_cnt <= w_drop_nxt;
      if (w_clear) begin
        r_q_cnt   <= '0;
        r_pend_wr <= '0;
        r_pend_rd <= '0;
        r_q_wr    <= '0;
        r_q_rd    <= '0;
      end else begin
        r_q_cnt <= r_q_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_accept) r_pend_wr <= r_pend_wr + PTR_W'(1);
        if (w_push) begin
          r_pend_rd <= r_pend_rd + PTR_W'(1);
          r_q_wr    <= r_q_wr + PTR_W'(1);
        end
        if (w_pop) r_q_rd <= r_q_rd + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pend_pc[r_pend_wr] <= pc_in;
    if (w_push) begin
      r_q_pc[r_q_wr]   <= r_pend_pc[r_pend_rd];
      r_q_inst[r_q_wr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch, r_perf_drop;
  logic        w_drop_resp;

  assign w_drop_resp = ((r_state == ST_RUN) && flush && w_resp_ok) ||
                       ((r_state == ST_DRAIN) && imem_rvalid && (r_drop_cnt != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetch <= '0;
      r_perf_drop  <= '0;
    end else begin
      if (w_pop)       r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_drop_resp) r_perf_drop  <= r_perf_drop + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_drop_cnt  = r_perf_drop;
`else
  assign perf_fetch_cnt = '0;
  assign perf_drop_cnt  = '0;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory side broke protocol.
  always_ff @(posedge clk) begin
    if (!reset) assert (!((r_state == ST_RUN) && imem_rvalid && (r_out_cnt == '0)));
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and randomized bench for inst_fetch_unit at DEPTH=4 and DEPTH=2.
module tb_inst_fetch_unit;
  localparam int AW = 64;
  localparam int IW = 32;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  logic          pv4, gnt4, rv4, rdy4, fl4, req4, prdy4, iv4;
  logic [AW-1:0] pc4, addr4, ipc4;
  logic [IW-1:0] rd4, iout4;
  logic [31:0]   pf4, pd4;

  logic          pv2, gnt2, rv2, rdy2, fl2, req2, prdy2, iv2;
  logic [AW-1:0] pc2, addr2, ipc2;
  logic [IW-1:0] rd2, iout2;
  logic [31:0]   pf2, pd2;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .pc_in(pc4), .pc_valid(pv4), .pc_ready(prdy4), .flush(fl4),
    .imem_req(req4), .imem_addr(addr4), .imem_gnt(gnt4), .imem_rvalid(rv4), .imem_rdata(rd4),
    .inst_valid(iv4), .inst_ready(rdy4), .inst_out(iout4), .inst_pc(ipc4),
    .perf_fetch_cnt(pf4), .perf_drop_cnt(pd4));

  inst_fetch_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .pc_in(pc2), .pc_valid(pv2), .pc_ready(prdy2), .flush(fl2),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2), .imem_rvalid(rv2), .imem_rdata(rd2),
    .inst_valid(iv2), .inst_ready(rdy2), .inst_out(iout2), .inst_pc(ipc2),
    .perf_fetch_cnt(pf2), .perf_drop_cnt(pd2));

  function automatic logic [31:0] dat(input logic [63:0] a);
    return 32'hA500_0000 ^ a[31:0];
  endfunction

  task automatic idle_all();
    pv4 = 0; pc4 = '0; gnt4 = 0; rv4 = 0; rd4 = '0; rdy4 = 0; fl4 = 0;
    pv2 = 0; pc2 = '0; gnt2 = 0; rv2 = 0; rd2 = '0; rdy2 = 0; fl2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  // One DEPTH=4 cycle: inputs change at the falling edge, outputs are settled 1 time unit later.
  task automatic drv4(input logic pv, input logic [63:0] pc, input logic gnt, input logic rv,
                      input logic [63:0] raddr, input logic rdy, input logic fl);
    @(negedge clk);
    pv4 = pv; pc4 = pc; gnt4 = gnt; rv4 = rv; rd4 = rv ? dat(raddr) : 32'h0; rdy4 = rdy; fl4 = fl;
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    pv4 = 1'b1; gnt4 = 1'b1; pc4 = 64'h40;
    reset = 1'b1;
    #3;
    n_checks++;
    if ({req4, prdy4, iv4} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: req/rdy/valid got %b required 000", {req4, prdy4, iv4});
    end
    n_checks++;
    if ({ipc4, iout4, pf4, pd4} !== '0) begin
      n_fail++; $display("FAIL reset_data: pc %h inst %h perf %h/%h required all 0", ipc4, iout4, pf4, pd4);
    end
    do_reset();
  endtask

  task automatic test_streaming();
    do_reset();
    drv4(1, 64'h0, 1, 0, 64'h0, 1, 0);
    n_checks++;
    if ({req4, prdy4, iv4, addr4} !== {3'b110, 64'h0}) begin
      n_fail++; $display("FAIL stream_c0: req/rdy/valid %b addr %h required 110 0", {req4, prdy4, iv4}, addr4);
    end
    drv4(1, 64'h4, 1, 1, 64'h0, 1, 0);
    n_checks++;
    if ({req4, prdy4, iv4} !== 3'b110) begin
      n_fail++; $display("FAIL stream_c1: req/rdy/valid %b required 110", {req4, prdy4, iv4});
    end
    drv4(1, 64'h8, 1, 1, 64'h4, 1, 0);
    n_checks++;
    if ({prdy4, iv4, ipc4, iout4} !== {2'b11, 64'h0, dat(64'h0)}) begin
      n_fail++; $display("FAIL stream_d0: rdy %b valid %b pc %h inst %h required 1 1 0 %h", prdy4, iv4, ipc4, iout4, dat(64'h0));
    end
    drv4(0, 64'h8, 0, 1, 64'h8, 1, 0);
    n_checks++;
    if ({req4, iv4, ipc4, iout4} !== {2'b01, 64'h4, dat(64'h4)}) begin
      n_fail++; $display("FAIL stream_d1: req %b valid %b pc %h inst %h required 0 1 4 %h", req4, iv4, ipc4, iout4, dat(64'h4));
    end
    drv4(0, 64'h8, 0, 0, 64'h0, 1, 0);
    n_checks++;
    if ({iv4, ipc4, iout4} !== {1'b1, 64'h8, dat(64'h8)}) begin
      n_fail++; $display("FAIL stream_d2: valid %b pc %h inst %h required 1 8 %h", iv4, ipc4, iout4, dat(64'h8));
    end
    drv4(0, 64'h8, 0, 0, 64'h0, 1, 0);
    n_checks++;
    if ({iv4, ipc4, iout4} !== '0) begin
      n_fail++; $display("FAIL stream_empty: valid %b pc %h inst %h required all 0", iv4, ipc4, iout4);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv4(1, (i < 5) ? 64'(4 * i) : 64'h10, 1, (i >= 1 && i <= 4), 64'(4 * (i - 1)), 0, 0);
      n_checks++;
      if (prdy4 !== (i <= 3)) begin
        n_fail++; $display("FAIL bp_accept[%0d]: pc_ready %b required %b", i, prdy4, (i <= 3));
      end
      if (prdy4 === 1'b1) acc++;
    end
    n_checks++;
    if (acc != 4 || req4 !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: accepts %0d req %b required 4 0", acc, req4);
    end
    drv4(1, 64'h10, 1, 0, 64'h0, 1, 0);
    n_checks++;
    if ({req4, iv4, ipc4, iout4} !== {2'b01, 64'h0, dat(64'h0)}) begin
      n_fail++; $display("FAIL bp_pop: req %b valid %b pc %h inst %h required 0 1 0 %h", req4, iv4, ipc4, iout4, dat(64'h0));
    end
    drv4(1, 64'h10, 1, 0, 64'h0, 0, 0);
    n_checks++;
    if ({req4, prdy4, addr4} !== {2'b11, 64'h10}) begin
      n_fail++; $display("FAIL bp_one_more: req/rdy %b addr %h required 11 10", {req4, prdy4}, addr4);
    end
    drv4(1, 64'h14, 1, 1, 64'h10, 0, 0);
    n_checks++;
    if ({req4, prdy4} !== 2'b00) begin
      n_fail++; $display("FAIL bp_refull: req/rdy %b required 00", {req4, prdy4});
    end
    for (int k = 0; k < 4; k++) begin
      drv4(0, 64'h14, 0, 0, 64'h0, 1, 0);
      n_checks++;
      if ({iv4, ipc4, iout4} !== {1'b1, 64'(4 + 4 * k), dat(64'(4 + 4 * k))}) begin
        n_fail++; $display("FAIL bp_order[%0d]: valid %b pc %h inst %h required 1 %h", k, iv4, ipc4, iout4, 64'(4 + 4 * k));
      end
    end
    drv4(0, 64'h14, 0, 0, 64'h0, 0, 0);
    n_checks++;
    if (iv4 !== 1'b0) begin
      n_fail++; $display("FAIL bp_drained: valid %b required 0", iv4);
    end
  endtask

  task automatic test_flush_drain();
    do_reset();
    drv4(1, 64'h0, 1, 0, 64'h0, 0, 0);
    drv4(1, 64'h4, 1, 1, 64'h0, 0, 0);
    drv4(1, 64'h8, 1, 0, 64'h0, 0, 0);
    drv4(1, 64'h100, 1, 0, 64'h0, 0, 1);
    n_checks++;
    if ({req4, prdy4, iv4, ipc4} !== {3'b001, 64'h0}) begin
      n_fail++; $display("FAIL fl_cycle: req/rdy/valid %b pc %h required 001 0", {req4, prdy4, iv4}, ipc4);
    end
    drv4(1, 64'h100, 1, 1, 64'h4, 0, 0);
    n_checks++;
    if ({req4, prdy4, iv4} !== 3'b000) begin
      n_fail++; $display("FAIL fl_drain1: req/rdy/valid %b required 000", {req4, prdy4, iv4});
    end
    drv4(1, 64'h100, 1, 1, 64'h8, 0, 0);
    n_checks++;
    if ({req4, prdy4, iv4} !== 3'b000) begin
      n_fail++; $display("FAIL fl_drain2: req/rdy/valid %b required 000", {req4, prdy4, iv4});
    end
    drv4(1, 64'h100, 1, 0, 64'h0, 0, 0);
    n_checks++;
    if ({req4, prdy4, addr4, pd4} !== {2'b11, 64'h100, PERF ? 32'd2 : 32'd0}) begin
      n_fail++; $display("FAIL fl_resume: req/rdy %b addr %h drops %0d required 11 100 %0d", {req4, prdy4}, addr4, pd4, PERF ? 2 : 0);
    end
    drv4(0, 64'h104, 0, 1, 64'h100, 1, 0);
    n_checks++;
    if (iv4 !== 1'b0) begin
      n_fail++; $display("FAIL fl_latency: valid %b required 0", iv4);
    end
    drv4(0, 64'h104, 0, 0, 64'h0, 1, 0);
    n_checks++;
    if ({iv4, ipc4, iout4} !== {1'b1, 64'h100, dat(64'h100)}) begin
      n_fail++; $display("FAIL fl_newpc: valid %b pc %h inst %h required 1 100 %h", iv4, ipc4, iout4, dat(64'h100));
    end
    drv4(0, 64'h104, 0, 0, 64'h0, 0, 0);
    n_checks++;
    if ({iv4, pf4} !== {1'b0, PERF ? 32'd1 : 32'd0}) begin
      n_fail++; $display("FAIL fl_fetchcnt: valid %b fetches %0d required 0 %0d", iv4, pf4, PERF ? 1 : 0);
    end
  endtask

  task automatic test_flush_with_resp();
    do_reset();
    drv4(1, 64'h0, 1, 0, 64'h0, 0, 0);
    drv4(1, 64'h200, 1, 1, 64'h0, 1, 1);
    n_checks++;
    if ({req4, prdy4, iv4} !== 3'b000) begin
      n_fail++; $display("FAIL flr_cycle: req/rdy/valid %b required 000", {req4, prdy4, iv4});
    end
    drv4(1, 64'h200, 1, 0, 64'h0, 1, 0);
    n_checks++;
    if ({req4, prdy4, iv4, addr4, pd4} !== {3'b110, 64'h200, PERF ? 32'd1 : 32'd0}) begin
      n_fail++; $display("FAIL flr_run: req/rdy/valid %b addr %h drops %0d required 110 200 %0d", {req4, prdy4, iv4}, addr4, pd4, PERF ? 1 : 0);
    end
    drv4(0, 64'h204, 0, 1, 64'h200, 1, 0);
    drv4(0, 64'h204, 0, 0, 64'h0, 1, 0);
    n_checks++;
    if ({iv4, ipc4, iout4} !== {1'b1, 64'h200, dat(64'h200)}) begin
      n_fail++; $display("FAIL flr_data: valid %b pc %h inst %h required 1 200 %h", iv4, ipc4, iout4, dat(64'h200));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drv4(1, 64'h0, 1, 0, 64'h0, 0, 0);
    drv4(1, 64'h4, 1, 1, 64'h0, 0, 0);
    drv4(1, 64'h8, 1, 0, 64'h0, 0, 0);
    n_checks++;
    if ({req4, prdy4, iv4} !== 3'b111) begin
      n_fail++; $display("FAIL ar_before: req/rdy/valid %b required 111", {req4, prdy4, iv4});
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({req4, prdy4, iv4, ipc4} !== '0) begin
      n_fail++; $display("FAIL ar_immediate: req/rdy/valid %b pc %h required 000 0", {req4, prdy4, iv4}, ipc4);
    end
    pv4 = 1'b0;
    #1 reset = 1'b0;
    drv4(1, 64'h300, 1, 0, 64'h0, 1, 0);
    n_checks++;
    if ({req4, prdy4, iv4, addr4} !== {3'b110, 64'h300}) begin
      n_fail++; $display("FAIL ar_restart: req/rdy/valid %b addr %h required 110 300", {req4, prdy4, iv4}, addr4);
    end
    drv4(0, 64'h304, 0, 1, 64'h300, 1, 0);
    drv4(0, 64'h304, 0, 0, 64'h0, 1, 0);
    n_checks++;
    if ({iv4, ipc4, iout4} !== {1'b1, 64'h300, dat(64'h300)}) begin
      n_fail++; $display("FAIL ar_data: valid %b pc %h inst %h required 1 300 %h", iv4, ipc4, iout4, dat(64'h300));
    end
  endtask

  typedef struct {
    logic [63:0] a;
    int          t;
  } mem_t;

  task automatic test_random_depth2();
    mem_t          mq[$];
    logic [63:0]   sb[$];
    logic [63:0]   pc = 64'h1000;
    int            delivered = 0;
    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      pv2  = ($urandom_range(0, 3) != 0);
      pc2  = pc;
      gnt2 = ($urandom_range(0, 1) != 0);
      rdy2 = ($urandom_range(0, 2) != 0);
      fl2  = ($urandom_range(0, 19) == 0);
      rv2  = (mq.size() > 0) && (mq[0].t < cyc) && ($urandom_range(0, 2) != 0);
      rd2  = rv2 ? dat(mq[0].a) : 32'h0;
      #1;
      if (iv2 && rdy2) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rnd_underflow: cycle %0d delivered pc %h with nothing expected", cyc, ipc2);
        end else begin
          if ({ipc2, iout2} !== {sb[0], dat(sb[0])}) begin
            n_fail++; $display("FAIL rnd_order: cycle %0d pc %h inst %h required %h %h", cyc, ipc2, iout2, sb[0], dat(sb[0]));
          end
          void'(sb.pop_front());
          delivered++;
        end
      end
      if (rv2) void'(mq.pop_front());
      if (prdy2) begin
        mq.push_back('{a: pc, t: cyc});
        sb.push_back(pc);
        n_checks++;
        if (mq.size() > 2 || addr2 !== pc) begin
          n_fail++; $display("FAIL rnd_overflow: cycle %0d in flight %0d addr %h required <=2 %h", cyc, mq.size(), addr2, pc);
        end
        pc = pc + 64'd4;
      end
      if (fl2) begin
        sb.delete();
        pc = 64'($urandom_range(0, 65535)) << 2;
      end
    end
    n_checks++;
    if (delivered < 50) begin
      n_fail++; $display("FAIL rnd_progress: delivered %0d required at least 50", delivered);
    end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_drain();
    test_flush_with_resp();
    test_async_reset();
    test_random_depth2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Fetch stage directly downstream of the 64-bit program counter register. Takes the PC value, issues in-order requests to instruction memory, and tags each returned 32-bit instruction with its PC. Buffers results in a small queue for decode. Supports a flush on branch/jump redirect that discards queued and in-flight fetches.

Parameters:
- ADDR_W, 64, PC/address width
- INST_W, 32, instruction width
- DEPTH, 4, queue depth and maximum outstanding-plus-queued entries; must be a power of 2, at least 2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pc_in  in  ADDR_W  current PC from the program counter
- pc_valid  in  1  pc_in is a valid fetch address
- pc_ready  out  1  pc_in accepted this cycle; the PC may advance
- flush  in  1  redirect; discard all queued and in-flight fetches
- imem_req  out  1  memory request valid
- imem_addr  out  ADDR_W  request address; equals pc_in
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant
- imem_rdata  in  INST_W  response instruction
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode consumes the head
- inst_out  out  INST_W  head instruction; 0 when inst_valid=0
- inst_pc  out  ADDR_W  head PC; 0 when inst_valid=0
- perf_fetch_cnt  out  32  instructions delivered (see Optional Feature)
- perf_drop_cnt  out  32  responses discarded by flush (see Optional Feature)

Behaviour:
- Reset (async, any time): state=RUN; out_cnt, q_cnt, drop_cnt and perf counters all 0; pending-PC FIFO and queue pointers 0.
- After reset: imem_req=0, pc_ready=0, inst_valid=0, inst_out=0, inst_pc=0. Storage arrays are not reset.
- Reset mid-operation abandons everything. Responses to pre-reset requests are a system error and are not required to be handled.
- Space condition: out_cnt + q_cnt < DEPTH.
- Request (combinational): imem_req = (state==RUN) && pc_valid && space && !flush.
- Accept = imem_req && imem_gnt. pc_ready = accept.
- On accept: pc_in is pushed into the pending-PC FIFO and out_cnt increments.
- Response in RUN: {pending head PC, imem_rdata} is pushed into the queue; pending pops; out_cnt decrements.
- Response latency: a response in cycle N gives inst_valid in cycle N+1. There is no bypass.
- Same-cycle accept and response: out_cnt is unchanged.
- Pop: inst_valid && inst_ready removes the head.
- Push and pop in the same cycle are legal, including at full; q_cnt is unchanged.
- rvalid with out_cnt==0 is ignored and triggers a simulation assertion.
- Flush in RUN (same edge):
  - queue and pending FIFO are cleared; q_cnt=0;
  - no request issues that cycle; a same-cycle response is dropped;
  - let r = out_cnt - imem_rvalid. If r>0: state->DRAIN, drop_cnt=r, out_cnt=0. Otherwise stay in RUN.
- DRAIN:
  - imem_req=0 and pc_ready=0;
  - each rvalid decrements drop_cnt and the data is discarded;
  - when drop_cnt reaches 0, state->RUN; requests resume on the next cycle.
  - flush in DRAIN has no further effect.
- A flush with an empty queue and no outstanding requests is a no-op apart from suppressing that cycle's request.
- Wrap-around: queue and pending pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - perf_fetch_cnt increments on every pop;
  - perf_drop_cnt increments on every discarded response (flush-cycle response or DRAIN response);
  - both counters wrap at 2^32 and are reset to 0.
- Undefined: both ports are constant 0 and no counter flops are synthesized.

Test Plan:
- Streaming, DEPTH=4: reset, then pc_valid=1, gnt=1, 1-cycle latency, inst_ready=1, PCs 0x0,0x4,0x8. Required: inst_pc 0x0,0x4,0x8 in order, each paired with its rdata; pc_ready=1 each cycle.
- Backpressure: inst_ready=0 while issuing. Required: exactly 4 accepts, then imem_req=0 and pc_ready=0; raising inst_ready for 1 cycle allows exactly 1 new accept.
- Flush with 2 in flight and 1 queued. Required: inst_valid=0 the next cycle; state DRAIN; the next 2 responses are discarded (perf_drop_cnt=2 when FETCH_PERF_EN is defined); imem_req resumes the cycle after the 2nd response, and the new PC 0x100 is fetched correctly.
- Flush coinciding with a response and out_cnt=1. Required: stays in RUN; the response is dropped; a request is issued the next cycle.
- Async reset mid-stream, asserted between clock edges. Required: inst_valid, imem_req and pc_ready go to 0 immediately; after release, fetch restarts from the presented pc_in.
- Ungated DEPTH=2 run of 1000 random gnt/rvalid/ready/flush cycles. Required: every delivered inst_pc matches a scoreboard of accepted-minus-flushed PCs; there is no overflow or underflow.
